// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_ISSUE,
    IDLE,
    SETUP,
    E_HI,
    WAIT
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
  localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;

  localparam int unsigned INIT_LEN = 4;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_xfer_t;

  // Fixed power-on command list, issued in order.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CMD_FUNCSET;
      2'd1:    return LCD_CMD_DISPON;
      2'd2:    return LCD_CMD_ENTRY;
      default: return LCD_CMD_CLEAR;
    endcase
  endfunction

  // Clear and home need the long post-E execution time.
  function automatic logic is_long_cmd(input lcd_xfer_t x);
    return !x.rs && (x.data == LCD_CMD_CLEAR || x.data == LCD_CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_write_sequencer_if.sv
// Two-requester valid/ready write port into the LCD sequencer.
interface lcd_write_sequencer_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves to the winner on every grant.
module lcd_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  // last = 1 means requester 1 won most recently, so requester 0 is preferred.
  logic last;

  // Grant selection: sole requester wins, contention goes to the one not granted last.
  always_comb begin
    grant = '0;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  // Pointer update; a grant always implies an accept since grant requires valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|grant) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780 write sequencer: power-up wait, fixed init list, then arbitrated
// character/command writes with registered E/RS/data bus timing.
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned E_HIGH_CYC = 12,
  parameter int unsigned EXEC_CYC   = 2500,
  parameter int unsigned CLR_CYC    = 82000,
  parameter int unsigned PWRUP_CYC  = 750000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_write_sequencer_if.slave req,
  output logic                 lcd_e,
  output logic                 lcd_rs,
  output logic [7:0]           data_lcd,
  output logic                 lcd_rw,
  output logic                 lcd_on,
  output logic                 lcd_blon,
  output logic                 init_done,
  output logic                 busy
);

  localparam int unsigned MAX_A   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int unsigned MAX_B   = (EXEC_CYC > CLR_CYC) ? EXEC_CYC : CLR_CYC;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_C > PWRUP_CYC) ? MAX_C : PWRUP_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_E_HI  = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lcd_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  lcd_xfer_t        cap, cap_next;
  logic [1:0]       init_idx, idx_next;
  logic             done_next;
  logic [1:0]       grant;
  logic             arb_en;

  assign arb_en         = (state == IDLE) && init_done;
  assign req.req0_ready = grant[0];
  assign req.req1_ready = grant[1];

  assign lcd_rs   = cap.rs;
  assign data_lcd = cap.data;
  assign lcd_rw   = 1'b0;

  lcd_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req.req1_valid, req.req0_valid}),
    .enable (arb_en),
    .grant  (grant)
  );

  // Next-state, counter reload on every state entry, capture and init bookkeeping.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cap_next   = cap;
    idx_next   = init_idx;
    done_next  = init_done;
    case (state)
      PWRUP: begin
        if (cnt == '0) state_next = INIT_ISSUE;
        else           cnt_next   = cnt - CNT_ONE;
      end
      INIT_ISSUE: begin
        cap_next   = '{rs: 1'b0, data: init_cmd(init_idx)};
        state_next = SETUP;
        cnt_next   = LD_SETUP;
      end
      IDLE: begin
        if (grant[0]) begin
          cap_next   = '{rs: req.req0_rs, data: req.req0_data};
          state_next = SETUP;
          cnt_next   = LD_SETUP;
        end else if (grant[1]) begin
          cap_next   = '{rs: req.req1_rs, data: req.req1_data};
          state_next = SETUP;
          cnt_next   = LD_SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_next = E_HI;
          cnt_next   = LD_E_HI;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      E_HI: begin
        if (cnt == '0) begin
          state_next = WAIT;
          cnt_next   = is_long_cmd(cap) ? LD_CLR : LD_EXEC;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          if (init_done) begin
            state_next = IDLE;
          end else if (init_idx == 2'(INIT_LEN - 1)) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            idx_next   = init_idx + 2'd1;
            state_next = INIT_ISSUE;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: state_next = PWRUP;
    endcase
  end

  // State and output registers; lcd_e/busy are decoded from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWRUP;
      cnt       <= LD_PWRUP;
      cap       <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
      lcd_e     <= 1'b0;
      busy      <= 1'b1;
      lcd_on    <= 1'b0;
      lcd_blon  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cap       <= cap_next;
      init_idx  <= idx_next;
      init_done <= done_next;
      lcd_e     <= (state_next == E_HI);
      busy      <= (state_next != IDLE);
      lcd_on    <= 1'b1;
      lcd_blon  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Testbench for lcd_write_sequencer: bus monitor plus per-scenario checks
// against transfer-level timing arithmetic.
module tb_lcd_write_sequencer;

  localparam int SETUP = 2;
  localparam int EHI   = 3;
  localparam int EXEC  = 5;
  localparam int CLR   = 20;
  localparam int PWRUP = 10;
  localparam int OVH   = 1 + SETUP + EHI;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_blon, init_done, busy;
  logic [7:0] data_lcd;

  lcd_write_sequencer_if bus ();

  lcd_write_sequencer #(
    .SETUP_CYC  (SETUP),
    .E_HIGH_CYC (EHI),
    .EXEC_CYC   (EXEC),
    .CLR_CYC    (CLR),
    .PWRUP_CYC  (PWRUP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (bus),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .data_lcd  (data_lcd),
    .lcd_rw    (lcd_rw),
    .lcd_on    (lcd_on),
    .lcd_blon  (lcd_blon),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int rel_cyc = 0;
  int done_cyc = 0;
  int model_last = 1;

  typedef struct { int who; logic rs; logic [7:0] data; int cyc; } acc_t;
  typedef struct { logic rs; logic [7:0] data; int rise; int width; bit stable; } pulse_t;
  acc_t   acc_log[$];
  pulse_t pulse_log[$];
  pulse_t cur;
  bit     e_prev = 1'b0;

  function automatic int wait_for(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02)) return CLR;
    return EXEC;
  endfunction

  // Bus monitor: logs accepts and each completed E pulse.
  always @(negedge clk) begin
    if (bus.req0_valid === 1'b1 && bus.req0_ready === 1'b1)
      acc_log.push_back('{who: 0, rs: bus.req0_rs, data: bus.req0_data, cyc: cyc});
    if (bus.req1_valid === 1'b1 && bus.req1_ready === 1'b1)
      acc_log.push_back('{who: 1, rs: bus.req1_rs, data: bus.req1_data, cyc: cyc});
    if (lcd_e === 1'b1 && !e_prev) begin
      cur.rs = lcd_rs; cur.data = data_lcd; cur.rise = cyc; cur.width = 0; cur.stable = 1'b1;
    end else if (lcd_e === 1'b1 && (lcd_rs !== cur.rs || data_lcd !== cur.data)) begin
      cur.stable = 1'b0;
    end
    if (lcd_e !== 1'b1 && e_prev) begin
      cur.width = cyc - cur.rise;
      pulse_log.push_back(cur);
    end
    e_prev = (lcd_e === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic wait_idle(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 200 && t < 0; i++) begin
      @(negedge clk);
      if (busy === 1'b0) t = cyc;
    end
    checks++;
    if (t < 0) begin failures++; $display("FAIL %s_idle_timeout got=busy exp=idle", tag); end
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b0; bus.req0_rs = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_rs = 1'b0; bus.req1_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    checks++; if (lcd_e !== 1'b0)    begin failures++; $display("FAIL rst_lcd_e got=%b exp=0", lcd_e); end
    checks++; if (lcd_rs !== 1'b0)   begin failures++; $display("FAIL rst_lcd_rs got=%b exp=0", lcd_rs); end
    checks++; if (data_lcd !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", data_lcd); end
    checks++; if (lcd_rw !== 1'b0)   begin failures++; $display("FAIL rst_lcd_rw got=%b exp=0", lcd_rw); end
    checks++; if (lcd_on !== 1'b0 || lcd_blon !== 1'b0) begin failures++; $display("FAIL rst_power got=%b%b exp=00", lcd_on, lcd_blon); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
    checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL rst_busy got=%b exp=1", busy); end
    checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      failures++; $display("FAIL rst_ready got=%b%b exp=00", bus.req1_ready, bus.req0_ready);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    rel_cyc = cyc; model_last = 1;
    acc_log.delete(); pulse_log.delete();
    @(negedge clk); @(negedge clk);
    checks++; if (lcd_on !== 1'b1 || lcd_blon !== 1'b1) begin failures++; $display("FAIL power_on got=%b%b exp=11", lcd_on, lcd_blon); end
    checks++; if (busy !== 1'b1 || lcd_rw !== 1'b0) begin failures++; $display("FAIL pwrup_busy got=%b/%b exp=1/0", busy, lcd_rw); end
  endtask

  task automatic test_init();
    logic [7:0] cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    int rise [4];
    int t = -1;
    int exp_done;
    rise[0] = rel_cyc + PWRUP + 1 + SETUP;
    for (int k = 1; k < 4; k++) rise[k] = rise[k-1] + EHI + wait_for(1'b0, cmds[k-1]) + 1 + SETUP;
    exp_done = rise[3] + EHI + wait_for(1'b0, cmds[3]);
    for (int i = 0; i < 1000 && t < 0; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) t = cyc;
    end
    done_cyc = t;
    checks++; if (t != exp_done) begin failures++; $display("FAIL init_done_cycle got=%0d exp=%0d", t - rel_cyc, exp_done - rel_cyc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL init_busy got=%b exp=0", busy); end
    checks++;
    if (pulse_log.size() != 4) begin
      failures++; $display("FAIL init_pulse_count got=%0d exp=4", pulse_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (pulse_log[k].rs !== 1'b0 || pulse_log[k].data !== cmds[k] || pulse_log[k].rise != rise[k] ||
            pulse_log[k].width != EHI || !pulse_log[k].stable) begin
          failures++;
          $display("FAIL init_pulse%0d got=rs%b %h @%0d w%0d s%0d exp=rs0 %h @%0d w%0d", k, pulse_log[k].rs,
                   pulse_log[k].data, pulse_log[k].rise - rel_cyc, pulse_log[k].width, pulse_log[k].stable,
                   cmds[k], rise[k] - rel_cyc, EHI);
        end
      end
    end
  endtask

  task automatic test_single();
    int t1 = -1, t2 = -1, t3;
    @(posedge clk); #1;
    acc_log.delete(); pulse_log.delete();
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h41;
    for (int i = 0; i < 50 && t1 < 0; i++) begin @(negedge clk); if (bus.req0_ready === 1'b1) t1 = cyc; end
    checks++; if (t1 < 0) begin failures++; $display("FAIL single_accept got=timeout exp=ready"); end
    @(posedge clk); #1 bus.req0_data = 8'h42;
    @(negedge clk);
    checks++;
    if (data_lcd !== 8'h41 || lcd_rs !== 1'b1 || lcd_e !== 1'b0 || bus.req0_ready !== 1'b0) begin
      failures++; $display("FAIL single_bus_t1 got=%h rs%b e%b rdy%b exp=41 rs1 e0 rdy0", data_lcd, lcd_rs, lcd_e, bus.req0_ready);
    end
    for (int i = 0; i < 50 && t2 < 0; i++) begin @(negedge clk); if (bus.req0_ready === 1'b1) t2 = cyc; end
    checks++; if (t2 - t1 != OVH + wait_for(1'b1, 8'h41)) begin failures++; $display("FAIL single_ready_gap got=%0d exp=%0d", t2 - t1, OVH + EXEC); end
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    wait_idle("single", t3);
    checks++; if (t3 - t2 != OVH + EXEC) begin failures++; $display("FAIL single_idle_gap got=%0d exp=%0d", t3 - t2, OVH + EXEC); end
    checks++;
    if (pulse_log.size() != 2 || pulse_log[0].data !== 8'h41 || pulse_log[0].rs !== 1'b1 ||
        pulse_log[0].rise != t1 + 1 + SETUP || pulse_log[0].width != EHI || !pulse_log[0].stable ||
        pulse_log[1].data !== 8'h42 || pulse_log[1].rise != t2 + 1 + SETUP) begin
      failures++; $display("FAIL single_pulses got=n%0d exp=41@%0d,42@%0d w%0d", pulse_log.size(), t1 + 1 + SETUP, t2 + 1 + SETUP, EHI);
    end
    model_last = 0;
  endtask

  task automatic test_clear_wait();
    int t1 = -1, t2 = -1, t3;
    @(posedge clk); #1;
    acc_log.delete(); pulse_log.delete();
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b0; bus.req1_data = 8'h01;
    for (int i = 0; i < 50 && t1 < 0; i++) begin @(negedge clk); if (bus.req1_ready === 1'b1) t1 = cyc; end
    checks++; if (t1 < 0) begin failures++; $display("FAIL clear_accept got=timeout exp=ready"); end
    @(posedge clk); #1 bus.req1_rs = 1'b1;
    for (int i = 0; i < 80 && t2 < 0; i++) begin @(negedge clk); if (bus.req1_ready === 1'b1) t2 = cyc; end
    checks++; if (t2 - t1 != OVH + CLR) begin failures++; $display("FAIL clear_long_wait got=%0d exp=%0d", t2 - t1, OVH + CLR); end
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    wait_idle("clear", t3);
    checks++; if (t3 - t2 != OVH + EXEC) begin failures++; $display("FAIL clear_data_wait got=%0d exp=%0d", t3 - t2, OVH + EXEC); end
    checks++;
    if (pulse_log.size() != 2 || pulse_log[0].rs !== 1'b0 || pulse_log[0].data !== 8'h01 ||
        pulse_log[1].rs !== 1'b1 || pulse_log[1].data !== 8'h01 || pulse_log[0].width != EHI) begin
      failures++; $display("FAIL clear_pulses got=n%0d exp=2 pulses rs0/rs1 data 01", pulse_log.size());
    end
    model_last = 1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] q0 [4] = '{8'h30, 8'h31, 8'h32, 8'h33};
    logic [7:0] q1 [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
    int exp_who[$];
    logic [7:0] exp_data[$];
    int a = 0, b = 0, g, last = model_last;
    int i0 = 0, i1 = 0, t;
    bit r0, r1, both = 1'b0;
    while (a < 4 || b < 4) begin
      if (a < 4 && b < 4) g = (last == 0) ? 1 : 0;
      else                g = (a < 4) ? 0 : 1;
      exp_who.push_back(g);
      if (g == 0) begin exp_data.push_back(q0[a]); a++; end
      else        begin exp_data.push_back(q1[b]); b++; end
      last = g;
    end
    model_last = last;
    @(posedge clk); #1;
    acc_log.delete(); pulse_log.delete();
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = q0[0];
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = q1[0];
    for (int c = 0; c < 400 && (i0 < 4 || i1 < 4); c++) begin
      @(negedge clk);
      r0 = (bus.req0_ready === 1'b1); r1 = (bus.req1_ready === 1'b1);
      if (r0 && r1) both = 1'b1;
      @(posedge clk); #1;
      if (r0) i0++;
      if (r1) i1++;
      bus.req0_valid = (i0 < 4); if (i0 < 4) bus.req0_data = q0[i0];
      bus.req1_valid = (i1 < 4); if (i1 < 4) bus.req1_data = q1[i1];
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_idle("b2b", t);
    @(posedge clk); #1;
    checks++; if (both) begin failures++; $display("FAIL b2b_dual_ready got=both exp=one"); end
    checks++;
    if (acc_log.size() != 8 || pulse_log.size() != 8) begin
      failures++; $display("FAIL b2b_count got=acc%0d pulses%0d exp=8", acc_log.size(), pulse_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (acc_log[k].who != exp_who[k] || pulse_log[k].data !== exp_data[k] || pulse_log[k].rs !== 1'b1 ||
            (k > 0 && acc_log[k].cyc - acc_log[k-1].cyc != OVH + EXEC)) begin
          failures++; $display("FAIL b2b_order%0d got=req%0d %h exp=req%0d %h", k, acc_log[k].who, pulse_log[k].data, exp_who[k], exp_data[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 10;
    logic [8:0] it0 [N];
    logic [8:0] it1 [N];
    logic [8:0] exp_q[$];
    int i0 = 0, i1 = 0, m_free, m_last = model_last, t;
    bit v0, v1, e0, e1;
    for (int i = 0; i < N; i++) begin
      it0[i] = 9'($urandom_range(0, 511));
      it1[i] = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 4) == 0) it0[i] = {1'b0, 8'($urandom_range(1, 2))};
      if ($urandom_range(0, 4) == 0) it1[i] = {1'b0, 8'($urandom_range(1, 2))};
    end
    @(posedge clk); #1;
    acc_log.delete(); pulse_log.delete();
    m_free = cyc;
    for (int c = 0; c < 3000 && (i0 < N || i1 < N); c++) begin
      v0 = (i0 < N) && ($urandom_range(0, 3) != 0);
      v1 = (i1 < N) && ($urandom_range(0, 3) != 0);
      bus.req0_valid = v0; if (i0 < N) {bus.req0_rs, bus.req0_data} = it0[i0];
      bus.req1_valid = v1; if (i1 < N) {bus.req1_rs, bus.req1_data} = it1[i1];
      @(negedge clk);
      e0 = 1'b0; e1 = 1'b0;
      if (cyc >= m_free) begin
        if (v0 && v1) begin if (m_last == 0) e1 = 1'b1; else e0 = 1'b1; end
        else if (v0)  e0 = 1'b1;
        else if (v1)  e1 = 1'b1;
      end
      checks++;
      if (bus.req0_ready !== e0 || bus.req1_ready !== e1) begin
        failures++; $display("FAIL rand_grant cyc%0d got=%b%b exp=%b%b", cyc, bus.req1_ready, bus.req0_ready, e1, e0);
      end
      if (e0) begin exp_q.push_back(it0[i0]); m_last = 0; m_free = cyc + OVH + wait_for(it0[i0][8], it0[i0][7:0]); i0++; end
      if (e1) begin exp_q.push_back(it1[i1]); m_last = 1; m_free = cyc + OVH + wait_for(it1[i1][8], it1[i1][7:0]); i1++; end
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    model_last = m_last;
    checks++; if (i0 < N || i1 < N) begin failures++; $display("FAIL rand_budget got=%0d/%0d exp=%0d/%0d", i0, i1, N, N); end
    wait_idle("rand", t);
    checks++; if (t != m_free && m_free > t - 200) begin failures++; $display("FAIL rand_idle_cycle got=%0d exp=%0d", t, m_free); end
    @(posedge clk); #1;
    checks++;
    if (pulse_log.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_pulse_count got=%0d exp=%0d", pulse_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        checks++;
        if ({pulse_log[k].rs, pulse_log[k].data} !== exp_q[k] || pulse_log[k].width != EHI || !pulse_log[k].stable) begin
          failures++; $display("FAIL rand_pulse%0d got=%h w%0d exp=%h w%0d", k, {pulse_log[k].rs, pulse_log[k].data}, pulse_log[k].width, exp_q[k], EHI);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int t1 = -1;
    bit seen = 1'b0;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h55;
    for (int i = 0; i < 50 && t1 < 0; i++) begin @(negedge clk); if (bus.req0_ready === 1'b1) t1 = cyc; end
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (lcd_e === 1'b1) seen = 1'b1; end
    checks++; if (!seen) begin failures++; $display("FAIL midrst_e_rise got=timeout exp=e_high"); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (lcd_e !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1 || data_lcd !== 8'h00) begin
      failures++; $display("FAIL midrst_outputs got=e%b done%b busy%b %h exp=e0 done0 busy1 00", lcd_e, init_done, busy, data_lcd);
    end
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h77;
    @(posedge clk); #1 rst = 1'b0;
    rel_cyc = cyc; model_last = 1;
    acc_log.delete(); pulse_log.delete();
  endtask

  task automatic test_pwrup_hold();
    int t, n55 = 0;
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    checks++;
    if (acc_log.size() != 1 || acc_log[0].who != 1 || acc_log[0].cyc != done_cyc || acc_log[0].data !== 8'h77) begin
      failures++; $display("FAIL hold_accept got=n%0d @%0d exp=n1 req1 77 @%0d", acc_log.size(),
                           acc_log.size() > 0 ? acc_log[0].cyc : -1, done_cyc);
    end
    wait_idle("hold", t);
    @(posedge clk); #1;
    foreach (pulse_log[k]) if (pulse_log[k].data === 8'h55) n55++;
    checks++; if (n55 != 0) begin failures++; $display("FAIL hold_discarded got=%0d exp=0", n55); end
    checks++;
    if (pulse_log.size() != 5 || pulse_log[4].data !== 8'h77 || pulse_log[4].rs !== 1'b1 ||
        pulse_log[4].rise != done_cyc + 1 + SETUP) begin
      failures++; $display("FAIL hold_pulse got=n%0d exp=5 last 77 @%0d", pulse_log.size(), done_cyc + 1 + SETUP);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single();
    test_clear_wait();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_init();
    test_pwrup_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
